regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32-entry integer register file. It merges two writeback sources onto the single register-file write port: the in-order pipeline writeback (P) and the long-latency unit writeback (M, mul/div and late loads). The arbiter is fixed-priority in favour of P, with a starvation limit for M. It drives RegWrite, Writeregister and Writedata from a registered output stage and filters out writes to x0.

## Interface
- DATA_W, 64, writeback data width
- REG_W, 5, register address width
- STARVE_MAX, 4, maximum consecutive cycles M may be refused while P wins; legal range 1..15
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high
- p_valid  input  1  pipeline writeback request
- p_ready  output  1  pipeline writeback accepted this cycle when p_valid=1
- p_rd  input  REG_W  pipeline destination register
- p_data  input  DATA_W  pipeline writeback data
- m_valid  input  1  long-latency unit writeback request; held with m_rd/m_data stable until accepted
- m_ready  output  1  long-latency writeback accepted this cycle when m_valid=1
- m_rd  input  REG_W  long-latency destination register
- m_data  input  DATA_W  long-latency writeback data
- rf_we  output  1  register-file RegWrite
- rf_waddr  output  REG_W  register-file Writeregister
- rf_wdata  output  DATA_W  register-file Writedata
- m_forced  output  1  high in the cycle M wins by starvation override (perf/debug)

## Operation
- Transfer on a port means valid & ready in the same cycle. At most one transfer happens per cycle.
- starve_cnt is internal, 4 bits, saturating at STARVE_MAX. force = (starve_cnt == STARVE_MAX).
- p_ready = !reset & !(m_valid & force).
- m_ready = !reset & (!p_valid | force).
- Both ready signals are combinational from valids and state. A requester's valid must never depend on its own ready.
- Grant:
  - M transfers if m_valid & m_ready.
  - Otherwise P transfers if p_valid & p_ready.
  - If neither condition holds, the cycle is idle.
- starve_cnt update, at the clock edge:
  - Cleared when M transfers or when m_valid=0.
  - Incremented, saturating, when m_valid=1 & m_ready=0.
- m_forced = m_valid & force & p_valid, which is the case where M displaced a valid P request.
- Output stage, on the edge following a transfer:
  - rf_waddr <= granted rd.
  - rf_wdata <= granted data.
  - rf_we <= (granted rd != 0).
- A write to x0 is still accepted (ready asserted, handshake completes) but produces rf_we=0. The address and data are still loaded.
- In an idle cycle: rf_we <= 0, while rf_waddr and rf_wdata hold their previous values.
- rf_* contents in the cycle rf_we=1 are the decode-stage forwarding source for a write not yet visible in the register file.
- The block holds no other storage: no queue and no skid buffer. A refused requester holds its request.

## Timing
- Reset (asynchronous, immediate) sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - starve_cnt=0.
  - p_ready=0, m_ready=0, m_forced=0, all while reset is high.
- Latency:
  - Transfer at edge N gives rf_we/rf_waddr/rf_wdata valid after edge N.
  - The register file captures the write at edge N+1.
  - Data is readable from the register file after edge N+1.
- Throughput: one writeback per cycle, sustained.
- Contention: with P valid every cycle and M valid continuously from cycle 0:
  - P wins cycles 0..STARVE_MAX-1.
  - M wins cycle STARVE_MAX.
  - P is stalled (p_ready=0) exactly one cycle.
  - starve_cnt returns to 0.
- M alone: m_ready=1 whenever P is idle, and M transfers in its first valid cycle.
- Saturation: starve_cnt never exceeds STARVE_MAX. With STARVE_MAX=1, M and P alternate under full contention.
- Reset mid-operation: a pending rf_we=1 is dropped (no write lands), and any unaccepted request is lost from the arbiter's view. Requesters restart after reset deasserts.
- After reset deasserts, ready signals follow the equations in the first cycle. There is no extra dead cycle.

## Test plan
- Reset check: assert reset mid-stream with rf_we=1 -> rf_we, rf_waddr, rf_wdata all 0 immediately; p_ready=m_ready=0 while reset is high.
- P only: p_rd=5, p_data=64'hDEAD_BEEF for one cycle -> p_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF; following cycle rf_we=0.
- x0 filter: p_rd=0, p_data=64'h1234 -> p_ready=1, next cycle rf_we=0.
- Contention, STARVE_MAX=4: p_valid held 1 (p_rd=1..), m_valid=1, m_rd=9, m_data=64'h55 from cycle 0 -> P accepted cycles 0-3; cycle 4 m_ready=1, p_ready=0, m_forced=1; cycle 5 rf_waddr=9, rf_wdata=64'h55; P resumes cycle 5.
- Simultaneous, not starved: p_valid=m_valid=1 with starve_cnt=0 -> only P transfers; m_ready=0; starve_cnt=1 next cycle.
- Back-to-back: M in cycle 0 (rd=3), P in cycles 1-2 (rd=4, rd=3) -> rf_we high 3 consecutive cycles with waddr 3, 4, 3 and matching data; a register-file model reads the last value written to x3.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline (P) and long-latency (M) writebacks onto the single register-file write port.
// P has fixed priority. M is forced through after STARVE_MAX consecutive refusals.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int REG_W      = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [REG_W-1:0]  p_rd,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [REG_W-1:0]  m_rd,
  input  logic [DATA_W-1:0] m_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              m_forced
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic force_m;
  logic m_xfer;
  logic p_xfer;

  // Ready is a pure function of the valids and the starvation state, so neither side waits on itself.
  always_comb begin
    force_m  = (starve_cnt_q == STARVE_LIM);
    p_ready  = !reset && !(m_valid && force_m);
    m_ready  = !reset && (!p_valid || force_m);
    m_forced = !reset && m_valid && p_valid && force_m;
    m_xfer   = m_valid && m_ready;
    p_xfer   = p_valid && p_ready && !m_xfer;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m_valid || m_xfer) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // x0 writes still complete the handshake and load address/data, but never raise the write enable.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (m_xfer) begin
      rf_we_d    = (m_rd != '0);
      rf_waddr_d = m_rd;
      rf_wdata_d = m_data;
    end else if (p_xfer) begin
      rf_we_d    = (p_rd != '0);
      rf_waddr_d = p_rd;
      rf_wdata_d = p_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a refusal-count model,
// with a bench-side register file fed from the DUT write port.
module tb_regfile_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        p_valid, p_ready, m_valid, m_ready;
  logic [4:0]  p_rd, m_rd, rf_waddr;
  logic [63:0] p_data, m_data, rf_wdata;
  logic        rf_we, m_forced;

  regfile_wb_arbiter #(.DATA_W(64), .REG_W(5), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .m_forced(m_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file driven only by the DUT write port.
  logic        mem_clear;
  logic [63:0] rf_mem [32];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= 64'd0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          refused = 0;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;
  logic [63:0] model_mem [32];

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    check_word(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic model_reset();
    refused   = 0;
    exp_we    = 1'b0;
    exp_waddr = 5'd0;
    exp_wdata = 64'd0;
  endtask

  // One cycle: drive, check readies mid-cycle, clock, advance the model, check the write port.
  task automatic apply_stimulus(input logic pv, input logic [4:0] prd, input logic [63:0] pdata,
                                input logic mv, input logic [4:0] mrd, input logic [63:0] mdata,
                                output logic m_taken);
    logic starved, e_p_ready, e_m_ready, e_forced;
    p_valid = pv; p_rd = prd; p_data = pdata;
    m_valid = mv; m_rd = mrd; m_data = mdata;
    #1;
    starved   = (refused == STARVE_MAX);
    e_m_ready = !pv || starved;
    e_p_ready = !(mv && starved);
    e_forced  = mv && pv && starved;
    check_output("p_ready", p_ready, e_p_ready);
    check_output("m_ready", m_ready, e_m_ready);
    check_output("m_forced", m_forced, e_forced);
    @(posedge clk);
    if (exp_we) model_mem[exp_waddr] = exp_wdata;
    m_taken = mv && e_m_ready;
    exp_we  = 1'b0;
    if (m_taken) begin
      exp_we = (mrd != 5'd0); exp_waddr = mrd; exp_wdata = mdata;
    end else if (pv && e_p_ready) begin
      exp_we = (prd != 5'd0); exp_waddr = prd; exp_wdata = pdata;
    end
    if (!mv || m_taken) refused = 0;
    else if (refused < STARVE_MAX) refused++;
    #1;
    check_output("rf_we", rf_we, exp_we);
    check_word("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_waddr});
    check_word("rf_wdata", rf_wdata, exp_wdata);
  endtask

  initial begin
    logic        mt, pv, mh_v;
    logic [4:0]  mh_rd;
    logic [63:0] mh_data;

    for (int k = 0; k < 32; k++) model_mem[k] = 64'd0;
    reset = 1'b1; mem_clear = 1'b1;
    p_valid = 1'b1; m_valid = 1'b1;
    p_rd = 5'd1; m_rd = 5'd2; p_data = 64'd0; m_data = 64'd0;
    #2;
    check_output("reset_p_ready", p_ready, 1'b0);
    check_output("reset_m_ready", m_ready, 1'b0);
    check_output("reset_m_forced", m_forced, 1'b0);
    check_output("reset_rf_we", rf_we, 1'b0);
    check_word("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check_word("reset_rf_wdata", rf_wdata, 64'd0);
    repeat (2) @(posedge clk);
    mem_clear = 1'b0;
    #1;
    reset = 1'b0; p_valid = 1'b0; m_valid = 1'b0;
    model_reset();

    // P only, then idle, then an x0 write
    apply_stimulus(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, mt);
    check_word("p_only_waddr", {59'd0, rf_waddr}, 64'd5);
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, mt);
    apply_stimulus(1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 64'd0, mt);
    check_output("x0_rf_we", rf_we, 1'b0);

    // Full contention: P wins four cycles, M forced on the fifth, P resumes
    for (int c = 0; c < 5; c++)
      apply_stimulus(1'b1, 5'(c + 1), 64'h100 + 64'(c), 1'b1, 5'd9, 64'h55, mt);
    check_output("contention_m_taken", mt, 1'b1);
    check_word("contention_waddr", {59'd0, rf_waddr}, 64'd9);
    check_word("contention_wdata", rf_wdata, 64'h55);
    apply_stimulus(1'b1, 5'd5, 64'h104, 1'b0, 5'd0, 64'd0, mt);
    check_word("p_resume_waddr", {59'd0, rf_waddr}, 64'd5);

    // Simultaneous, not starved: P wins, M held and then goes alone
    apply_stimulus(1'b1, 5'd6, 64'h66, 1'b1, 5'd8, 64'h88, mt);
    check_output("simul_m_refused", mt, 1'b0);
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 64'h88, mt);
    check_output("m_alone_taken", mt, 1'b1);

    // Back-to-back: M x3, P x4, P x3
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'hA3A3, mt);
    apply_stimulus(1'b1, 5'd4, 64'hB4B4, 1'b0, 5'd0, 64'd0, mt);
    apply_stimulus(1'b1, 5'd3, 64'hC3C3, 1'b0, 5'd0, 64'd0, mt);
    check_output("b2b_third_we", rf_we, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, mt);
    check_word("regfile_x3", rf_mem[3], 64'hC3C3);
    check_word("regfile_x4", rf_mem[4], 64'hB4B4);

    // Reset while a write is pending: it must never land
    apply_stimulus(1'b1, 5'd7, 64'hCAFE_F00D, 1'b0, 5'd0, 64'd0, mt);
    check_output("pre_reset_we", rf_we, 1'b1);
    p_valid = 1'b1; m_valid = 1'b1; reset = 1'b1;
    #1;
    check_output("mid_reset_rf_we", rf_we, 1'b0);
    check_word("mid_reset_waddr", {59'd0, rf_waddr}, 64'd0);
    check_word("mid_reset_wdata", rf_wdata, 64'd0);
    check_output("mid_reset_p_ready", p_ready, 1'b0);
    check_output("mid_reset_m_ready", m_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_word("dropped_write_x7", rf_mem[7], 64'd0);
    reset = 1'b0; p_valid = 1'b0; m_valid = 1'b0;

    // Random traffic; M keeps its request stable until accepted
    mh_v = 1'b0; mh_rd = 5'd0; mh_data = 64'd0;
    for (int i = 0; i < 400; i++) begin
      if (!mh_v && ($urandom_range(0, 1) == 1)) begin
        mh_v = 1'b1;
        mh_rd = 5'($urandom_range(0, 31));
        mh_data = {$urandom, $urandom};
      end
      pv = ($urandom_range(0, 3) != 0);
      apply_stimulus(pv, 5'($urandom_range(0, 31)), {$urandom, $urandom}, mh_v, mh_rd, mh_data, mt);
      if (mt) mh_v = 1'b0;
    end
    repeat (2) apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, mt);

    for (int k = 0; k < 32; k++)
      check_word($sformatf("regfile_x%0d", k), rf_mem[k], model_mem[k]);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
